cycle_sequencer: RTL

CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

---
 rtl/cycle_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cycle_sequencer
// Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with a
//            memory-wait timeout, retired-instruction counter, HALT and ERROR.
// Revision : 1.0 - initial release
// ============================================================================
module cycle_sequencer #(
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt_i,
    input  logic              memren_i,
    input  logic              memwren_i,
    input  logic              regwren_i,
    input  logic              pcsel_i,
    input  logic              taken_i,
    input  logic              imem_ack_i,
    input  logic              dmem_ack_i,
    output logic              imem_req_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic              insn_we_o,
    output logic              regfile_we_o,
    output logic              pc_we_o,
    output logic              pc_src_o,
    output logic              retired_o,
    output logic [DWIDTH-1:0] instret_o,
    output logic [2:0]        state_o,
    output logic              halted_o,
    output logic              err_o
);

    localparam int WCW = $clog2(TIMEOUT + 2);

    localparam logic [2:0] c_FETCH  = 3'd0;
    localparam logic [2:0] c_DECODE = 3'd1;
    localparam logic [2:0] c_EXEC   = 3'd2;
    localparam logic [2:0] c_MEM    = 3'd3;
    localparam logic [2:0] c_WB     = 3'd4;
    localparam logic [2:0] c_HALT   = 3'd5;
    localparam logic [2:0] c_ERROR  = 3'd6;

    localparam logic [WCW-1:0] c_WAIT_LIMIT = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [2:0]        state_q, state_d;
    logic [WCW-1:0]    wait_q, wait_d;
    logic [DWIDTH-1:0] instret_q, instret_d;
    logic              w_expired;

    // Last permitted unacknowledged request cycle; an ack in it still wins.
    assign w_expired = (TIMEOUT > 0) && (wait_q == c_WAIT_LIMIT);

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        instret_d = instret_q;
        case (state_q)
            c_FETCH: begin
                if (imem_ack_i) begin
                    state_d = c_DECODE;
                end else if (w_expired) begin
                    state_d = c_ERROR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            c_DECODE: begin
                state_d = halt_i ? c_HALT : c_EXEC;
            end
            c_EXEC: begin
                if (memren_i | memwren_i) begin
                    state_d = c_MEM;
                    wait_d  = '0;
                end else begin
                    state_d = c_WB;
                end
            end
            c_MEM: begin
                if (dmem_ack_i) begin
                    state_d = c_WB;
                end else if (w_expired) begin
                    state_d = c_ERROR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            c_WB: begin
                state_d   = c_FETCH;
                wait_d    = '0;
                instret_d = instret_q + 1'b1;
            end
            c_HALT, c_ERROR: begin
                state_d = state_q;
            end
            default: begin
                state_d = c_ERROR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= c_FETCH;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    // Strobes decode straight from the current state so reset drops them at once.
    assign imem_req_o   = (state_q == c_FETCH);
    assign insn_we_o    = (state_q == c_FETCH) & imem_ack_i;
    assign dmem_req_o   = (state_q == c_MEM);
    assign dmem_we_o    = (state_q == c_MEM) & memwren_i;
    assign regfile_we_o = (state_q == c_WB) & regwren_i;
    assign pc_we_o      = (state_q == c_WB);
    assign pc_src_o     = (state_q == c_WB) & pcsel_i & taken_i;
    assign retired_o    = (state_q == c_WB);
    assign instret_o    = instret_q;
    assign state_o      = state_q;
    assign halted_o     = (state_q == c_HALT);
    assign err_o        = (state_q == c_ERROR);

endmodule
`default_nettype wire
